ysyx_23060136_ifu_bht: RTL and testbench
========================================

Name: ysyx_23060136_ifu_bht

Overview:
Branch history table and target buffer in the IFU, directly upstream of the EXU branch-resolution stage. It gives a combinational taken/not-taken prediction and a target for the current fetch PC. That prediction travels down the pipe as the B-type `pre_take` bit. The block trains its 2-bit saturating counters from the EXU resolution interface (`BHT_pc`, `BHT_pre_true`, `BHT_pre_false`, actual outcome, target). It also keeps wrapping performance counters for resolved branches and mispredictions.

Parameters:
- BITS_W, 32, data/PC width.
- ENTRIES, 16, table depth; power of two, at least 2.
- IDX_W, 4, log2(ENTRIES).
- TAG_W, 8, tag bits taken from the PC above the index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- IFU_pc  in  BITS_W  current fetch PC.
- IFU_pre_take  out  1  prediction for IFU_pc: 1 = taken.
- IFU_pre_target  out  BITS_W  next PC: stored target if predicted taken, else IFU_pc+4.
- BHT_pc  in  BITS_W  PC of the resolved B-type branch.
- BHT_pre_true  in  1  prediction for BHT_pc was correct.
- BHT_pre_false  in  1  prediction for BHT_pc was wrong.
- BHT_actual_take  in  1  resolved direction.
- BHT_target  in  BITS_W  resolved branch target (branch_target from EXU).
- perf_branch_cnt  out  32  resolved B-type branches.
- perf_miss_cnt  out  32  mispredictions.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Index and tag: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. pc[1:0] is ignored.
- Entry contents: valid, tag[TAG_W], target[BITS_W], cnt[2].
- Counter encoding: 00 strongly not-taken (SNT), 01 weakly not-taken (WNT), 10 weakly taken (WT), 11 strongly taken (ST).
- Reset: every valid=0 and cnt=01. target and tag are don't-care. perf counters = 0. With all entries invalid, IFU_pre_take=0 and IFU_pre_target=IFU_pc+4 in the first cycle after reset.
- Lookup (combinational, zero latency):
  - hit = valid[idx] & tag[idx]==tag(IFU_pc).
  - IFU_pre_take = hit & cnt[idx][1].
  - IFU_pre_target = IFU_pre_take ? target[idx] : IFU_pc+4; the +4 wraps modulo 2^BITS_W.
- Update event: upd = BHT_pre_true | BHT_pre_false.
  - Both high at once is illegal; pre_false takes priority for perf counting.
  - The table update itself depends only on BHT_actual_take.
- Update rules, on a clock edge with upd=1, using the entry at idx(BHT_pc):
  - Tag hit, taken: cnt saturating +1 (11 stays 11); target <= BHT_target.
  - Tag hit, not taken: cnt saturating −1 (00 stays 00).
  - Miss (invalid or tag differs), taken: allocate or replace the entry: valid=1, tag=tag(BHT_pc), target=BHT_target, cnt=10.
  - Miss, not taken: no change; never evict on not-taken.
- No update cycles: upd=0 leaves the table untouched.
- Read/write collision: when the lookup index equals the update index in the same cycle, lookup returns the pre-update value. The write is visible from the next cycle; there is no bypass.
- Performance counters:
  - perf_branch_cnt += 1 on each upd cycle.
  - perf_miss_cnt += 1 on each cycle with BHT_pre_false=1.
  - Both are 32-bit and wrap FFFF_FFFF→0.
- Reset mid-operation: rst overrides any same-cycle update. The table and counters return to reset values at that edge.
- Implementation constraint: the table is flops, not SRAM. No X may reach IFU_pre_take after reset.

Test Plan:
1. Reset, then IFU_pc=0x8000_0000 → IFU_pre_take=0, IFU_pre_target=0x8000_0004; perf counters = 0.
2. Cold allocate: BHT_pc=0x8000_0010, pre_false=1, actual_take=1, target=0x8000_0100.
   - Next cycle, IFU_pc=0x8000_0010 → pre_take=1, pre_target=0x8000_0100.
   - perf_miss_cnt=1, perf_branch_cnt=1.
3. Saturation and decay on the entry from scenario 2 (cnt=10):
   - Two taken updates → cnt reaches 11 and stays there.
   - Then two not-taken updates → 10, then 01; lookup pre_take goes 1,1,1,0 across the four updates.
   - Four further not-taken updates → cnt stays at 00.
4. Alias conflict: entry at 0x8000_0010 is valid.
   - Not-taken update at 0x8000_0050 (same idx, different tag) → entry unchanged; lookup at 0x8000_0010 is still predicted taken.
   - Taken update at 0x8000_0050 → entry replaced; lookup at 0x8000_0010 now misses (pre_take=0).
5. Collision: update (not taken) at idx 4 in the same cycle as a lookup at idx 4.
   - Lookup that cycle shows the old counter.
   - Lookup the next cycle shows the decremented counter.
6. Counters and reset:
   - Force perf_branch_cnt to FFFF_FFFF, then one update → wraps to 0.
   - Assert rst together with a taken update → the entry is not allocated and all outputs return to reset values.

Source files
------------

// File: rtl/ysyx_23060136_ifu_bht.sv
// IFU branch history table + target buffer: 2-bit saturating counters with tagged targets,
// zero-latency lookup for the fetch PC, training from EXU branch resolution.
module ysyx_23060136_ifu_bht #(
   parameter int BITS_W  = 32,
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4,
   parameter int TAG_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BITS_W-1:0] IFU_pc,
   output logic              IFU_pre_take,
   output logic [BITS_W-1:0] IFU_pre_target,
   input  logic [BITS_W-1:0] BHT_pc,
   input  logic              BHT_pre_true,
   input  logic              BHT_pre_false,
   input  logic              BHT_actual_take,
   input  logic [BITS_W-1:0] BHT_target,
   output logic [31:0]       perf_branch_cnt,
   output logic [31:0]       perf_miss_cnt
);

   logic [ENTRIES-1:0] valid_q;
   logic [1:0]         cnt_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [BITS_W-1:0]  target_q [ENTRIES];
   logic [31:0]        branch_cnt_q;
   logic [31:0]        miss_cnt_q;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'b01;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

   logic [IDX_W-1:0] rd_idx;
   logic [TAG_W-1:0] rd_tag;
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] wr_tag;
   logic             rd_hit;
   logic             wr_hit;
   logic             upd;

   assign rd_idx = IFU_pc[IDX_W+1:2];
   assign rd_tag = IFU_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign wr_idx = BHT_pc[IDX_W+1:2];
   assign wr_tag = BHT_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign upd    = BHT_pre_true | BHT_pre_false;

   // Lookup reads the registered table only, so a same-cycle update is seen next cycle
   assign rd_hit         = valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag);
   assign wr_hit         = valid_q[wr_idx] & (tag_q[wr_idx] == wr_tag);
   assign IFU_pre_take   = rd_hit & cnt_q[rd_idx][1];
   assign IFU_pre_target = IFU_pre_take ? target_q[rd_idx] : IFU_pc + BITS_W'(4);

   assign perf_branch_cnt = branch_cnt_q;
   assign perf_miss_cnt   = miss_cnt_q;

   // Control state: valid bits and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b01;
      end else if (upd) begin
         if (wr_hit) begin
            cnt_q[wr_idx] <= BHT_actual_take ? sat_inc(cnt_q[wr_idx]) : sat_dec(cnt_q[wr_idx]);
         end else if (BHT_actual_take) begin
            valid_q[wr_idx] <= 1'b1;
            cnt_q[wr_idx]   <= 2'b10;
         end
      end
   end

   // Tag/target need no reset; a hit rewrites the same tag, a miss allocates it
   always_ff @(posedge clk) begin
      if (!rst && upd && BHT_actual_take) begin
         tag_q[wr_idx]    <= wr_tag;
         target_q[wr_idx] <= BHT_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt_q <= '0;
         miss_cnt_q   <= '0;
      end else begin
         if (upd)           branch_cnt_q <= branch_cnt_q + 32'd1;
         if (BHT_pre_false) miss_cnt_q   <= miss_cnt_q + 32'd1;
      end
   end

   logic unused_pc_bits;
   assign unused_pc_bits = ^{IFU_pc[1:0], IFU_pc[BITS_W-1:IDX_W+TAG_W+2],
                             BHT_pc[1:0], BHT_pc[BITS_W-1:IDX_W+TAG_W+2]};

endmodule

// File: tb/tb_ysyx_23060136_ifu_bht.sv
// Directed bench for the IFU BHT: table of lookup/update vectors plus reset and counter-wrap sequences.
module tb_ysyx_23060136_ifu_bht;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] IFU_pc;
   logic        IFU_pre_take;
   logic [31:0] IFU_pre_target;
   logic [31:0] BHT_pc;
   logic        BHT_pre_true;
   logic        BHT_pre_false;
   logic        BHT_actual_take;
   logic [31:0] BHT_target;
   logic [31:0] perf_branch_cnt;
   logic [31:0] perf_miss_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_23060136_ifu_bht dut (
      .clk             (clk),
      .rst             (rst),
      .IFU_pc          (IFU_pc),
      .IFU_pre_take    (IFU_pre_take),
      .IFU_pre_target  (IFU_pre_target),
      .BHT_pc          (BHT_pc),
      .BHT_pre_true    (BHT_pre_true),
      .BHT_pre_false   (BHT_pre_false),
      .BHT_actual_take (BHT_actual_take),
      .BHT_target      (BHT_target),
      .perf_branch_cnt (perf_branch_cnt),
      .perf_miss_cnt   (perf_miss_cnt)
   );

   // Expected outputs are those seen before the row's own update lands
   typedef struct {
      logic [31:0] ifu_pc;
      logic [31:0] bht_pc;
      logic        pt;
      logic        pf;
      logic        tk;
      logic [31:0] tgt;
      logic        e_take;
      logic [31:0] e_tgt;
      logic [31:0] e_br;
      logic [31:0] e_miss;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] ipc, input logic [31:0] bpc, input logic pt,
                        input logic pf, input logic tk, input logic [31:0] tgt);
      IFU_pc          = ipc;
      BHT_pc          = bpc;
      BHT_pre_true    = pt;
      BHT_pre_false   = pf;
      BHT_actual_take = tk;
      BHT_target      = tgt;
   endtask

   task automatic check_out(input string tag, input logic e_take, input logic [31:0] e_tgt,
                            input logic [31:0] e_br, input logic [31:0] e_miss);
      check({tag, ".take"},   {31'd0, IFU_pre_take}, {31'd0, e_take});
      check({tag, ".target"}, IFU_pre_target, e_tgt);
      check({tag, ".branch"}, perf_branch_cnt, e_br);
      check({tag, ".miss"},   perf_miss_cnt, e_miss);
   endtask

   initial begin
      // ifu_pc, bht_pc, pre_true, pre_false, take, target, exp_take, exp_target, exp_branch, exp_miss
      vq.push_back('{32'h8000_0000, 32'h0, 0, 0, 0, 32'h0,          0, 32'h8000_0004, 0, 0});
      vq.push_back('{32'h8000_0010, 32'h8000_0010, 0, 1, 1, 32'h8000_0100, 0, 32'h8000_0014, 0, 0});
      vq.push_back('{32'h8000_0010, 32'h8000_0010, 1, 0, 1, 32'h8000_0100, 1, 32'h8000_0100, 1, 1});
      vq.push_back('{32'h8000_0010, 32'h8000_0010, 1, 0, 1, 32'h8000_0100, 1, 32'h8000_0100, 2, 1});
      vq.push_back('{32'h8000_0010, 32'h8000_0010, 0, 1, 0, 32'h0,          1, 32'h8000_0100, 3, 1});
      vq.push_back('{32'h8000_0010, 32'h8000_0010, 1, 0, 0, 32'h0,          1, 32'h8000_0100, 4, 2});
      vq.push_back('{32'h8000_0010, 32'h0, 0, 0, 0, 32'h0,          0, 32'h8000_0014, 5, 2});
      vq.push_back('{32'h8000_0010, 32'h8000_0010, 1, 0, 0, 32'h0,  0, 32'h8000_0014, 5, 2});
      vq.push_back('{32'h8000_0010, 32'h8000_0010, 1, 0, 0, 32'h0,  0, 32'h8000_0014, 6, 2});
      vq.push_back('{32'h8000_0010, 32'h8000_0010, 1, 0, 0, 32'h0,  0, 32'h8000_0014, 7, 2});
      vq.push_back('{32'h8000_0010, 32'h8000_0010, 1, 0, 0, 32'h0,  0, 32'h8000_0014, 8, 2});
      vq.push_back('{32'h8000_0010, 32'h8000_0010, 1, 0, 1, 32'h8000_0200, 0, 32'h8000_0014, 9, 2});
      vq.push_back('{32'h8000_0010, 32'h8000_0010, 1, 0, 1, 32'h8000_0200, 0, 32'h8000_0014, 10, 2});
      vq.push_back('{32'h8000_0010, 32'h0, 0, 0, 0, 32'h0,          1, 32'h8000_0200, 11, 2});
      vq.push_back('{32'h8000_0010, 32'h8000_0050, 1, 0, 0, 32'h0,  1, 32'h8000_0200, 11, 2});
      vq.push_back('{32'h8000_0010, 32'h8000_0050, 0, 1, 1, 32'h8000_0300, 1, 32'h8000_0200, 12, 2});
      vq.push_back('{32'h8000_0010, 32'h0, 0, 0, 0, 32'h0,          0, 32'h8000_0014, 13, 3});
      vq.push_back('{32'h8000_0050, 32'h0, 0, 0, 0, 32'h0,          1, 32'h8000_0300, 13, 3});
      vq.push_back('{32'h8000_0050, 32'h8000_0050, 1, 0, 0, 32'h0,  1, 32'h8000_0300, 13, 3});
      vq.push_back('{32'h8000_0050, 32'h0, 0, 0, 0, 32'h0,          0, 32'h8000_0054, 14, 3});
      vq.push_back('{32'hFFFF_FFFC, 32'h0, 0, 0, 0, 32'h0,          0, 32'h0000_0000, 14, 3});
      vq.push_back('{32'h8000_0020, 32'h8000_0020, 1, 0, 0, 32'h0,  0, 32'h8000_0024, 14, 3});
      vq.push_back('{32'h8000_0020, 32'h0, 0, 0, 0, 32'h0,          0, 32'h8000_0024, 15, 3});

      rst = 1'b1;
      drive(32'h8000_0000, 32'h0, 0, 0, 0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         if (i != 0) @(negedge clk);
         drive(vq[i].ifu_pc, vq[i].bht_pc, vq[i].pt, vq[i].pf, vq[i].tk, vq[i].tgt);
         #1;
         check_out($sformatf("vec%0d", i), vq[i].e_take, vq[i].e_tgt, vq[i].e_br, vq[i].e_miss);
      end

      // Branch counter wrap: preload all-ones, then one taken update at 0x8000_0050 (cnt 01 -> 10)
      @(negedge clk);
      drive(32'h8000_0050, 32'h0, 0, 0, 0, 32'h0);
      force dut.branch_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.branch_cnt_q;
      #1;
      check("wrap.preload", perf_branch_cnt, 32'hFFFF_FFFF);
      drive(32'h8000_0050, 32'h8000_0050, 1, 0, 1, 32'h8000_0500);
      @(negedge clk);
      drive(32'h8000_0050, 32'h0, 0, 0, 0, 32'h0);
      #1;
      check_out("wrap", 1'b1, 32'h8000_0500, 32'h0, 32'd3);

      // Reset together with a taken update: nothing allocated, everything back to reset values
      @(negedge clk);
      rst = 1'b1;
      drive(32'h8000_0040, 32'h8000_0040, 0, 1, 1, 32'h8000_0400);
      @(negedge clk);
      rst = 1'b0;
      drive(32'h8000_0040, 32'h0, 0, 0, 0, 32'h0);
      #1;
      check_out("rst_upd", 1'b0, 32'h8000_0044, 32'h0, 32'h0);
      IFU_pc = 32'h8000_0050;
      #1;
      check_out("rst_clr", 1'b0, 32'h8000_0054, 32'h0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
